// File: rtl/time_set_ctrl.sv
// Time-of-day counter with RUN/SET_H/SET_M/SET_S adjustment FSM.
// Optional `HOURLY_CHIME_EN adds a one-cycle chime on each counted hour boundary.
module time_set_ctrl #(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_btn,
  input  logic        inc_btn,
  input  logic        dec_btn,
  output logic [16:0] seconds,
  output logic [1:0]  state,
  output logic        sec_pulse,
  output logic        chime
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_t;

  mode_t         state_q, state_d;
  logic [PW-1:0] prescaler;
  logic [16:0]   seconds_q, adj_seconds;
  logic          sec_pulse_q;
  logic          tick;
  logic [4:0]    hours;
  logic [5:0]    mins, secs;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_btn) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    state = state_q;
  end

  assign hours = 5'(seconds_q / 17'd3600);
  assign mins  = 6'((seconds_q % 17'd3600) / 17'd60);
  assign secs  = 6'(seconds_q % 17'd60);
  assign tick  = (state_q == RUN) && (prescaler == PRE_MAX);

  // Each field wraps within itself, so the other fields are untouched.
  always_comb begin
    adj_seconds = seconds_q;
    case (state_q)
      SET_H: begin
        if (inc_btn) adj_seconds = (hours == 5'd23) ? seconds_q - 17'd82800 : seconds_q + 17'd3600;
        else         adj_seconds = (hours == 5'd0)  ? seconds_q + 17'd82800 : seconds_q - 17'd3600;
      end
      SET_M: begin
        if (inc_btn) adj_seconds = (mins == 6'd59) ? seconds_q - 17'd3540 : seconds_q + 17'd60;
        else         adj_seconds = (mins == 6'd0)  ? seconds_q + 17'd3540 : seconds_q - 17'd60;
      end
      SET_S: begin
        if (inc_btn) adj_seconds = (secs == 6'd59) ? seconds_q - 17'd59 : seconds_q + 17'd1;
        else         adj_seconds = (secs == 6'd0)  ? seconds_q + 17'd59 : seconds_q - 17'd1;
      end
      default: adj_seconds = seconds_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seconds_q   <= 17'd0;
      prescaler   <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q <= 1'b0;
      if (state_q == RUN) begin
        if (tick) begin
          prescaler   <= '0;
          seconds_q   <= (seconds_q == 17'd86399) ? 17'd0 : seconds_q + 17'd1;
          sec_pulse_q <= 1'b1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end else begin
        prescaler <= '0;
        // mode_btn wins; simultaneous inc and dec cancel out.
        if (!mode_btn && (inc_btn ^ dec_btn)) seconds_q <= adj_seconds;
      end
    end
  end

  assign seconds   = seconds_q;
  assign sec_pulse = sec_pulse_q;

`ifdef HOURLY_CHIME_EN
  logic chime_q;

  always_ff @(posedge clk) begin
    if (!rst_n) chime_q <= 1'b0;
    else        chime_q <= tick && (mins == 6'd59) && (secs == 6'd59);
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl (CLK_HZ=4): directed scenarios plus
// random button traffic checked against an hh:mm:ss reference model.
module tb_time_set_ctrl;

  localparam int CLK_HZ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic        dec_btn = 1'b0;
  logic [16:0] seconds;
  logic [1:0]  state;
  logic        sec_pulse;
  logic        chime;

  int total = 0;
  int bad = 0;

  int m_sec = 0;
  int m_state = 0;
  int m_pre = 0;
  int m_pulse = 0;
  int m_chime = 0;

`ifdef HOURLY_CHIME_EN
  localparam int CHIME_ON = 1;
`else
  localparam int CHIME_ON = 0;
`endif

  time_set_ctrl #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_btn(mode_btn),
    .inc_btn(inc_btn),
    .dec_btn(dec_btn),
    .seconds(seconds),
    .state(state),
    .sec_pulse(sec_pulse),
    .chime(chime)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Reference model works on hours/minutes/seconds fields, one clock edge at a time.
  task automatic modelStep(input bit r, input bit m, input bit i, input bit d);
    int h, mi, s;
    if (!r) begin
      m_sec = 0; m_state = 0; m_pre = 0; m_pulse = 0; m_chime = 0;
      return;
    end
    m_pulse = 0;
    m_chime = 0;
    if (m_state == 0) begin
      if (m_pre == CLK_HZ - 1) begin
        m_pre = 0;
        m_sec = (m_sec + 1) % 86400;
        m_pulse = 1;
        m_chime = (CHIME_ON != 0 && m_sec % 3600 == 0) ? 1 : 0;
      end else begin
        m_pre++;
      end
    end else begin
      m_pre = 0;
    end
    if (m) begin
      m_state = (m_state + 1) % 4;
    end else if (m_state != 0 && (i != d)) begin
      h = m_sec / 3600;
      mi = (m_sec / 60) % 60;
      s = m_sec % 60;
      case (m_state)
        1: h  = i ? (h + 1) % 24  : (h + 23) % 24;
        2: mi = i ? (mi + 1) % 60 : (mi + 59) % 60;
        default: s = i ? (s + 1) % 60 : (s + 59) % 60;
      endcase
      m_sec = h * 3600 + mi * 60 + s;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit m, input bit i, input bit d);
    rst_n = r; mode_btn = m; inc_btn = i; dec_btn = d;
    @(posedge clk);
    modelStep(r, m, i, d);
    #1;
    checkOutput("seconds", int'(seconds), m_sec);
    checkOutput("state", int'(state), m_state);
    checkOutput("sec_pulse", int'(sec_pulse), m_pulse);
    checkOutput("chime", int'(chime), m_chime);
  endtask

  initial begin
    int pulses;
    bit r, m, i, d;

    // Reset, then eight RUN cycles: two seconds, pulse every fourth cycle
    applyStimulus(0, 1, 1, 0);
    checkOutput("reset_seconds", int'(seconds), 0);
    checkOutput("reset_state", int'(state), 0);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("pulse_phase", int'(sec_pulse), (k % 4 == 0) ? 1 : 0);
      pulses += int'(sec_pulse);
    end
    checkOutput("run_8_cycles", int'(seconds), 2);
    checkOutput("pulse_count", pulses, 2);

    // Preload 23:59:59 and watch the day wrap
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("hour_dec_wrap", int'(seconds), 82800);
    applyStimulus(1, 0, 1, 0);
    checkOutput("hour_inc_wrap", int'(seconds), 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("preload_86399", int'(seconds), 86399);
    applyStimulus(1, 1, 0, 0);
    checkOutput("back_to_run", int'(state), 0);
    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0);
    checkOutput("no_early_tick", int'(seconds), 86399);
    applyStimulus(1, 0, 0, 0);
    checkOutput("day_wrap", int'(seconds), 0);
    checkOutput("day_wrap_pulse", int'(sec_pulse), 1);
    checkOutput("day_wrap_chime", int'(chime), CHIME_ON);

    // 01:00:59 -> SET_S inc -> 3600, then SET_M dec -> 7140
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("preload_3659", int'(seconds), 3659);
    applyStimulus(1, 0, 1, 0);
    checkOutput("sec_inc_wrap", int'(seconds), 3600);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("min_dec_wrap", int'(seconds), 7140);

    // Mode beats inc; inc+dec together cancel
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("mode_priority_state", int'(state), 2);
    checkOutput("mode_priority_secs", int'(seconds), 7140);
    applyStimulus(1, 0, 1, 1);
    checkOutput("inc_dec_cancel", int'(seconds), 7140);

    // Reset in SET_M with seconds=5000 (01:23:20)
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    for (int k = 0; k < 23; k++) applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    for (int k = 0; k < 20; k++) applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("preload_5000", int'(seconds), 5000);
    checkOutput("in_set_m", int'(state), 2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("mid_set_reset_secs", int'(seconds), 0);
    checkOutput("mid_set_reset_state", int'(state), 0);

    // Random button traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) != 0);
      m = ($urandom_range(0, 9) == 0);
      i = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 2) == 0);
      applyStimulus(r, m, i, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
